// File: rtl/adder_gather.sv
// adder_gather: serial-to-parallel gather stage feeding a NUM-input adder tree.
// Packs NUM consecutive operands from a valid/ready stream into lanes and
// presents the completed group on a registered bus with a one-cycle valid pulse.
//
// Optional feature macro: ADDER_GATHER_PAD_EN
//   defined   - in_last on an accepted operand closes the group early; the
//               unfilled upper lanes are emitted as zero (+0.0).
//   undefined - in_last is ignored; groups close only after NUM operands.
//
// Fill state table (idx_q):
//   state | meaning
//   IDLE  | idx_q == 0, no partial group held
//   FILL  | idx_q  > 0, lanes 0..idx_q-1 hold a partial group
module adder_gather #(
  parameter int BITS     = 16,
  parameter int NUM      = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  input  logic                  in_last,
  input  logic                  flush,
  output logic [NUM*BITS-1:0]   data_out,
  output logic                  valid_out,
  output logic [CNT_BITS-1:0]   group_cnt
);

  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

`ifdef ADDER_GATHER_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  logic [NUM-1:0][BITS-1:0] fill_q, fill_d;
  logic [NUM-1:0][BITS-1:0] out_q, out_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic                     valid_q, valid_d;
  logic                     ready_q;

  logic                     accept;
  logic                     at_last;
  logic                     early;
  logic                     complete;
  logic [IDX_W-1:0]         base_idx;
  logic [NUM-1:0][BITS-1:0] base_fill;

  // Next-state for fill bank, output bank, index and counter.
  // A flush is applied first so an operand arriving in the same cycle
  // starts a fresh group at lane 0.
  always_comb begin
    accept    = in_valid & ready_q;
    base_idx  = flush ? '0 : idx_q;
    base_fill = flush ? '0 : fill_q;
    at_last   = (base_idx == LAST_IDX);
    early     = PAD_EN & in_last;
    complete  = accept & (at_last | early);

    fill_d  = base_fill;
    idx_d   = base_idx;
    out_d   = out_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;

    if (accept) begin
      if (complete) begin
        // Group closes now: the completing operand bypasses the fill bank,
        // lanes above it (only possible on an early close) become zero.
        for (int k = 0; k < NUM; k++) begin
          if (IDX_W'(k) < base_idx)       out_d[k] = base_fill[k];
          else if (IDX_W'(k) == base_idx) out_d[k] = in_data;
          else                            out_d[k] = '0;
        end
        fill_d  = '0;
        idx_d   = '0;
        valid_d = 1'b1;
        cnt_d   = cnt_q + CNT_BITS'(1);
      end else begin
        for (int k = 0; k < NUM; k++) begin
          if (IDX_W'(k) == base_idx) fill_d[k] = in_data;
        end
        idx_d = base_idx + IDX_W'(1);
      end
    end
  end

  // State registers; in_ready rises on the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_q  <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ready_q <= 1'b1;
    end
  end

  assign in_ready  = ready_q;
  assign data_out  = out_q;
  assign valid_out = valid_q;
  assign group_cnt = cnt_q;

endmodule

// File: tb/tb_adder_gather.sv
// Scoreboard bench for adder_gather (NUM=4, BITS=16, CNT_BITS=2).
// The driver feeds a queue-based reference model that pushes expected groups;
// a negedge monitor pops and compares whenever valid_out is seen.
module tb_adder_gather;

  localparam int BITS     = 16;
  localparam int NUM      = 4;
  localparam int CNT_BITS = 2;
  localparam int W        = NUM * BITS;

`ifdef ADDER_GATHER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                resetn;
  logic                in_valid;
  logic                in_ready;
  logic [BITS-1:0]     in_data;
  logic                in_last;
  logic                flush;
  logic [W-1:0]        data_out;
  logic                valid_out;
  logic [CNT_BITS-1:0] group_cnt;

  adder_gather #(.BITS(BITS), .NUM(NUM), .CNT_BITS(CNT_BITS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .data_out  (data_out),
    .valid_out (valid_out),
    .group_cnt (group_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cnt;
    longint       due;
  } exp_t;

  exp_t            exp_q[$];
  logic [BITS-1:0] partial[$];
  int              cnt_m;
  logic [W-1:0]    shown_data;
  int              shown_cnt;
  longint          cyc = 0;
  bit              released;
  bit              mon_en = 1'b0;
  int              checks = 0;
  int              failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready is expected from the first edge that sees reset deasserted.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) released <= 1'b0;
    else         released <= 1'b1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a list of pending operands; a group is emitted when it
  // reaches NUM entries or, with padding, when in_last is seen.
  task automatic model_step(input bit v, input logic [BITS-1:0] d, input bit l, input bit f);
    exp_t e;
    if (f) partial.delete();
    if (v) begin
      partial.push_back(d);
      if (partial.size() == NUM || (PAD && l)) begin
        e.data = '0;
        foreach (partial[k]) e.data[k*BITS +: BITS] = partial[k];
        cnt_m = (cnt_m + 1) % (1 << CNT_BITS);
        e.cnt = cnt_m;
        e.due = cyc + 1;
        exp_q.push_back(e);
        partial.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input logic [BITS-1:0] d, input bit l, input bit f);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    flush    = f;
    model_step(v, d, l, f);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset(input int n);
    resetn = 1'b0;
    partial.delete();
    cnt_m      = 0;
    shown_data = '0;
    shown_cnt  = 0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("ready_in_reset", in_ready, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", in_ready, 1'b1);
  endtask

  // Monitor: compares every cycle; pops the scoreboard on each valid_out.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!resetn) begin
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_data", data_out, '0);
        chk("rst_cnt", group_cnt, '0);
        chk("rst_ready", in_ready, 1'b0);
      end else begin
        chk("in_ready", in_ready, released);
        if (valid_out) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", valid_out, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("group_data", data_out, e.data);
            chk("group_cnt", group_cnt, e.cnt);
            chk("latency_cycle", cyc, e.due);
            shown_data = e.data;
            shown_cnt  = e.cnt;
          end
        end else begin
          chk("data_stable", data_out, shown_data);
          chk("cnt_stable", group_cnt, shown_cnt);
          if (exp_q.size() != 0) chk("late_group", cyc < exp_q[0].due, 1'b1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
    cnt_m = 0; shown_data = '0; shown_cnt = 0;
    #1;
    chk("por_valid", valid_out, 1'b0);
    chk("por_data", data_out, '0);
    chk("por_cnt", group_cnt, '0);
    mon_en = 1'b1;
    apply_reset(3);
    idle(1);

    // First directed group.
    drive(1'b1, 16'h3C00, 1'b0, 1'b0);
    drive(1'b1, 16'h4000, 1'b0, 1'b0);
    drive(1'b1, 16'h4200, 1'b0, 1'b0);
    drive(1'b1, 16'h4400, 1'b0, 1'b0);
    idle(3);

    // Twelve back-to-back operands.
    for (int i = 0; i < 12; i++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
    idle(3);

    // Partial group discarded by a flush carrying a new operand.
    drive(1'b1, 16'h1111, 1'b0, 1'b0);
    drive(1'b1, 16'h2222, 1'b0, 1'b0);
    drive(1'b1, 16'h5555, 1'b0, 1'b1);
    drive(1'b1, 16'h6666, 1'b0, 1'b0);
    drive(1'b1, 16'h7777, 1'b0, 1'b0);
    drive(1'b1, 16'h8888, 1'b0, 1'b0);
    idle(2);

    // Flush with nothing pending.
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // in_last on the second operand, then two more.
    drive(1'b1, 16'h3C00, 1'b0, 1'b0);
    drive(1'b1, 16'h4000, 1'b1, 1'b0);
    drive(1'b1, 16'h4200, 1'b0, 1'b0);
    drive(1'b1, 16'h4400, 1'b0, 1'b0);
    idle(2);
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0);
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Flush plus in_last operand; in_last on the final lane.
    drive(1'b1, 16'h0101, 1'b0, 1'b0);
    drive(1'b1, 16'h0202, 1'b1, 1'b1);
    drive(1'b1, 16'h0303, 1'b0, 1'b0);
    drive(1'b1, 16'h0404, 1'b0, 1'b0);
    drive(1'b1, 16'h0505, 1'b0, 1'b0);
    drive(1'b1, 16'h0606, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // Randomised mix of valid, flush and in_last.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // Reset in the middle of a partial group.
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
    drive(1'b1, 16'hBEEF, 1'b0, 1'b0);
    apply_reset(2);
    chk("post_reset_cnt", group_cnt, '0);
    for (int i = 0; i < 5 * NUM; i++) drive(1'b1, 16'($urandom), 1'b0, 1'b0);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
